// File: rtl/join_buffered.sv
// N-input join with a DEPTH-entry FIFO per channel; one output beat carries the
// head of every FIFO once all channels are non-empty. Input ready never sees out_ready.
module join_buffered #(
  parameter int NUM_INPUTS = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_in,
  input  logic [NUM_INPUTS-1:0]                data_in_valid,
  output logic [NUM_INPUTS-1:0]                data_in_ready,
  output logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_out,
  output logic                                 data_out_valid,
  input  logic                                 data_out_ready
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [NUM_INPUTS][DEPTH];
  logic [CW-1:0]         r_wptr  [NUM_INPUTS];
  logic [CW-1:0]         r_rptr  [NUM_INPUTS];
  logic [CW-1:0]         r_count [NUM_INPUTS];

  logic [NUM_INPUTS-1:0]                 w_not_full;
  logic [NUM_INPUTS-1:0]                 w_not_empty;
  logic [NUM_INPUTS-1:0]                 w_push;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] w_head;
  logic                                  w_pop;

  // Head select is a decoded mux so pointer width need not match the index width.
  always_comb begin
    w_not_full  = '0;
    w_not_empty = '0;
    w_head      = '0;
    for (int c = 0; c < NUM_INPUTS; c++) begin
      w_not_full[c]  = (r_count[c] != FULL);
      w_not_empty[c] = (r_count[c] != '0);
      for (int e = 0; e < DEPTH; e++) begin
        if (r_rptr[c] == CW'(e)) w_head[c] = r_mem[c][e];
      end
    end
  end

  assign data_in_ready  = rst ? '0 : w_not_full;
  assign data_out_valid = !rst && (&w_not_empty);
  assign data_out       = rst ? '0 : w_head;
  assign w_push         = data_in_valid & data_in_ready;
  assign w_pop          = data_out_valid & data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_INPUTS; c++) begin
        r_wptr[c]  <= '0;
        r_rptr[c]  <= '0;
        r_count[c] <= '0;
        for (int e = 0; e < DEPTH; e++) r_mem[c][e] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_INPUTS; c++) begin
        if (w_push[c]) begin
          for (int e = 0; e < DEPTH; e++) begin
            if (r_wptr[c] == CW'(e)) r_mem[c][e] <= data_in[c];
          end
          r_wptr[c] <= (r_wptr[c] == LAST) ? '0 : r_wptr[c] + CW'(1);
        end
        if (w_pop) begin
          r_rptr[c] <= (r_rptr[c] == LAST) ? '0 : r_rptr[c] + CW'(1);
        end
        case ({w_push[c], w_pop})
          2'b10:   r_count[c] <= r_count[c] + CW'(1);
          2'b01:   r_count[c] <= r_count[c] - CW'(1);
          default: r_count[c] <= r_count[c];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_join_buffered.sv
// Directed bench for join_buffered: 2-ch/DEPTH=2 scenarios plus 3-ch streaming at
// DEPTH=2 and DEPTH=1, all expectations hand-derived.
module tb_join_buffered;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][7:0] din2, dout2;
  logic [1:0]      vin2, rdy2;
  logic            vout2, oready2;

  logic [2:0][7:0] din3, dout3, dout1, dout_m;
  logic [2:0]      vin3, vin_a, vin_b, rdy3, rdy1, rdy_m;
  logic            vout3, vout1, vout_m, oready3;
  bit              sel = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int ncyc;

  assign vin_a  = sel ? 3'b000 : vin3;
  assign vin_b  = sel ? vin3 : 3'b000;
  assign rdy_m  = sel ? rdy1 : rdy3;
  assign vout_m = sel ? vout1 : vout3;
  assign dout_m = sel ? dout1 : dout3;

  join_buffered #(.NUM_INPUTS(2), .DATA_WIDTH(8), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_in(din2), .data_in_valid(vin2), .data_in_ready(rdy2),
    .data_out(dout2), .data_out_valid(vout2), .data_out_ready(oready2));

  join_buffered #(.NUM_INPUTS(3), .DATA_WIDTH(8), .DEPTH(2)) u_dut3 (
    .clk(clk), .rst(rst), .data_in(din3), .data_in_valid(vin_a), .data_in_ready(rdy3),
    .data_out(dout3), .data_out_valid(vout3), .data_out_ready(oready3));

  join_buffered #(.NUM_INPUTS(3), .DATA_WIDTH(8), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(din3), .data_in_valid(vin_b), .data_in_ready(rdy1),
    .data_out(dout1), .data_out_valid(vout1), .data_out_ready(oready3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] beat_val(input int c, input int k);
    return 8'((k * 7 + c * 49 + 3) & 255);
  endfunction

  task automatic stream(input bit s, input int nb, output int nc);
    int kp[3];
    int ko;
    ko = 0;
    nc = 0;
    for (int c = 0; c < 3; c++) kp[c] = 0;
    sel = s;
    oready3 = 1'b1;
    while (ko < nb && nc < 400) begin
      for (int c = 0; c < 3; c++) begin
        din3[c] = beat_val(c, kp[c]);
        vin3[c] = (kp[c] < nb);
      end
      #1;
      if (s) chk("d1_valid_alternates", vout_m, nc[0]);
      for (int c = 0; c < 3; c++) if (vin3[c] && rdy_m[c]) kp[c]++;
      if (vout_m) begin
        chk("stream_beat", dout_m, {beat_val(2, ko), beat_val(1, ko), beat_val(0, ko)});
        ko++;
      end
      nc++;
      cyc();
    end
    vin3 = '0;
    chk("stream_all_beats", ko, nb);
  endtask

  initial begin
    rst = 1'b1; din2 = {8'h66, 8'h55}; vin2 = 2'b11; oready2 = 1'b1;
    din3 = '0; vin3 = '0; oready3 = 1'b0;

    // reset held with inputs valid: nothing may be accepted
    repeat (3) begin
      cyc();
      #1;
      chk("rst_ready", rdy2, 2'b00);
      chk("rst_valid", vout2, 1'b0);
      chk("rst_data", dout2, 16'h0000);
    end
    cyc();
    rst = 1'b0; vin2 = 2'b00;
    #1;
    chk("post_rst_ready", rdy2, 2'b11);
    chk("post_rst_valid", vout2, 1'b0);
    chk("post_rst_data", dout2, 16'h0000);

    // skewed arrival: ch0 at t0, ch1 at t3
    vin2 = 2'b01; din2[0] = 8'h11;
    #1; chk("skew_t0_valid", vout2, 1'b0);
    cyc();
    vin2 = 2'b00;
    #1; chk("skew_t1_valid", vout2, 1'b0);
    chk("skew_t1_ch0", dout2[0], 8'h11);
    cyc();
    #1; chk("skew_t2_valid", vout2, 1'b0);
    cyc();
    vin2 = 2'b10; din2[1] = 8'h22;
    #1; chk("skew_t3_valid", vout2, 1'b0);
    cyc();
    vin2 = 2'b00;
    #1; chk("skew_t4_valid", vout2, 1'b1);
    chk("skew_t4_data", dout2, 16'h2211);
    cyc();
    #1; chk("skew_single_pop", vout2, 1'b0);
    chk("skew_ready_after", rdy2, 2'b11);

    // backpressure on ch0 with out_ready low
    oready2 = 1'b0; vin2 = 2'b01; din2[0] = 8'h01;
    #1; chk("bp_rdy_1", rdy2[0], 1'b1);
    cyc();
    din2[0] = 8'h02;
    #1; chk("bp_rdy_2", rdy2[0], 1'b1);
    cyc();
    din2[0] = 8'h03;
    #1; chk("bp_rdy_full", rdy2[0], 1'b0);
    cyc();
    #1; chk("bp_rdy_still_full", rdy2[0], 1'b0);
    chk("bp_head", dout2[0], 8'h01);
    chk("bp_valid", vout2, 1'b0);
    oready2 = 1'b1; vin2 = 2'b11; din2[1] = 8'hB1;
    cyc();
    din2[1] = 8'hB2;
    #1; chk("bp_out_1", dout2, 16'hB101);
    chk("bp_out_1_valid", vout2, 1'b1);
    chk("bp_rdy_full_on_pop", rdy2[0], 1'b0);
    cyc();
    din2[1] = 8'hB3;
    #1; chk("bp_out_2", dout2, 16'hB202);
    chk("bp_rdy_after_pop", rdy2[0], 1'b1);
    cyc();
    vin2 = 2'b00;
    #1; chk("bp_out_3", dout2, 16'hB303);
    chk("bp_out_3_valid", vout2, 1'b1);
    cyc();
    #1; chk("bp_drained", vout2, 1'b0);

    // mid-operation reset with two ch0 beats buffered
    vin2 = 2'b01; din2[0] = 8'hC1;
    cyc();
    din2[0] = 8'hC2;
    cyc();
    vin2 = 2'b00; rst = 1'b1;
    #1; chk("mid_rst_ready", rdy2, 2'b00);
    chk("mid_rst_valid", vout2, 1'b0);
    cyc();
    rst = 1'b0; vin2 = 2'b11; din2 = {8'h0B, 8'h0A};
    #1; chk("mid_rst_cleared", vout2, 1'b0);
    chk("mid_rst_ready_back", rdy2, 2'b11);
    cyc();
    vin2 = 2'b00;
    #1; chk("mid_rst_out", dout2, 16'h0B0A);
    chk("mid_rst_out_valid", vout2, 1'b1);
    cyc();
    #1; chk("mid_rst_no_stale", vout2, 1'b0);

    // streaming throughput, 3 channels
    stream(1'b0, 100, ncyc);
    chk("stream_d2_cycles", ncyc, 101);
    stream(1'b1, 10, ncyc);
    chk("stream_d1_cycles", ncyc, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/join_buffered.md
# join_buffered

Parametrised N-input join with a per-input FIFO on every channel. It synchronises NUM_INPUTS valid/ready streams into one output stream and emits one beat carrying all channels once every channel holds data. The per-input buffering decouples producers that arrive at different times. No combinational path runs from out_ready to any in_ready, so the block can sit between pipeline stages without lengthening ready chains. It replaces the two-input passthrough join wherever operand streams (e.g. weights and activations) arrive with skew.

## Interface
- NUM_INPUTS, 2: number of input channels, ≥2.
- DATA_WIDTH, 8: bits per channel beat, ≥1.
- DEPTH, 2: entries per input FIFO, ≥1 (any integer, not only powers of two).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  per-channel input data.
- data_in_valid  input  [NUM_INPUTS-1:0]  per-channel valid.
- data_in_ready  output  [NUM_INPUTS-1:0]  per-channel ready.
- data_out  output  [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  joined beat; channel i is the head of FIFO i.
- data_out_valid  output  1  joined beat available.
- data_out_ready  input  1  downstream accepts beat.

## Operation
- Each channel i has a DEPTH-entry circular FIFO with:
  - write pointer, read pointer and occupancy count of width $clog2(DEPTH+1);
  - pointers wrapping from DEPTH-1 to 0 explicitly.
- Push on channel i when data_in_valid[i] & data_in_ready[i]. The entry is written at the write pointer, and the write pointer and count advance.
- data_in_ready[i] = !rst & (count[i] != DEPTH).
  - Depends on registered state only; never on data_out_ready or a same-cycle pop.
- data_out_valid = !rst & (every count[i] != 0).
- data_out[i] = entry at read pointer of FIFO i (first-word fall-through).
- Pop when data_out_valid & data_out_ready. All NUM_INPUTS FIFOs pop together: read pointers advance and counts decrement.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance.
- Channels are independent on the input side. A channel may run up to DEPTH beats ahead of the slowest channel.
- Pushes never overwrite. Pops never underflow, because valid requires all counts non-zero.
- Beat order is preserved per channel. Output beat k joins the k-th beat of every channel.

## Timing
- Reset (rst high at a clock edge): all counts, pointers and storage clear to 0.
- While rst is high:
  - data_in_ready = 0;
  - data_out_valid = 0;
  - data_out = 0.
- The first cycle after reset deasserts: data_in_ready = all ones, data_out_valid = 0, data_out = 0.
- Latency: a beat pushed in cycle t is visible on data_out in cycle t+1. data_out_valid rises in t+1 if the other channels are already non-empty.
- Throughput:
  - DEPTH ≥ 2: one beat per cycle sustained.
  - DEPTH = 1: at most one beat per two cycles, because a full slot is not reported ready in the cycle it pops.
- data_out and data_out_valid are stable while data_out_valid=1 & data_out_ready=0.
- Reset asserted mid-operation discards all buffered beats with no output beat. The next accepted beat is channel beat 0.
- Backpressure: with data_out_ready=0, channel i stops accepting exactly when it holds DEPTH beats.

## Test plan
- Reset checks: hold rst 3 cycles with inputs valid.
  - During rst: data_in_ready=00 and data_out_valid=0, with no pushes.
  - After release: data_in_ready=11 and data_out=0.
- Skewed arrival (NUM_INPUTS=2, DEPTH=2):
  - Push ch0=0x11 at t0 and ch1=0x22 at t3, with out_ready=1.
  - Required: data_out_valid low until t4; at t4 data_out={0x22,0x11}; single pop.
- Full backpressure (DEPTH=2):
  - Hold out_ready=0 and drive ch0 valid continuously with 0x01, 0x02, 0x03.
  - Required: data_in_ready[0] drops after 2 accepts; 0x03 is not accepted until a pop.
  - Then raise out_ready, push ch1 values: output order 0x01, 0x02, 0x03.
- Streaming: NUM_INPUTS=3, DEPTH=2, all channels valid every cycle, out_ready=1, 100 beats.
  - Required: 100 outputs in 101 cycles, in order, no drops.
- DEPTH=1 throughput: the same streaming stimulus.
  - Required: output valid every other cycle; 10 beats take 20 cycles.
- Mid-operation reset:
  - With 2 beats buffered on ch0 and 0 on ch1, pulse rst 1 cycle, then push ch0=0xA, ch1=0xB.
  - Required: the next output is {0xB,0xA} and no stale ch0 beat appears.
